ieee754_to_u16: RTL

IEEE754_TO_U16 -- requirements
Module: ieee754_to_u16

---
 rtl/ieee754_conv_pkg.sv | 24 ++
 rtl/fp32_unpack.sv | 36 +++
 rtl/ieee754_to_u16.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ieee754_conv_pkg.sv
// Shared definitions for the float-to-unsigned conversion block.
//   - conv_state_e : conversion FSM states (also exported on the debug port)
//   - FP32 field widths and exponent bias
//   - bit positions inside the 3-bit {nan, neg, ovf} flag vector
package ieee754_conv_pkg;

  localparam int FP32_BIAS = 127;
  localparam int EXP_W     = 8;
  localparam int MANT_W    = 23;
  localparam int SIG_W     = MANT_W + 1;  // significand with hidden one

  localparam int FLAG_NAN  = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_ROUND  = 3'd3,
    ST_DONE   = 3'd4
  } conv_state_e;

endpackage

// File: rtl/fp32_unpack.sv
// Combinational split of an IEEE 754 single-precision word and operand
// class decode.
// Ports:
//   fp_i      : 32-bit operand
//   sign_o    : sign bit
//   is_zero_o : exponent field is 0 (zero or denormal)
//   is_nan_o  : exponent all-ones with nonzero mantissa
//   is_inf_o  : exponent all-ones with zero mantissa
//   e_o       : unbiased exponent (exp - 127), signed
//   sig_o     : {1, mantissa}, 24 bits
module fp32_unpack
  import ieee754_conv_pkg::*;
(
  input  logic [31:0]       fp_i,
  output logic              sign_o,
  output logic              is_zero_o,
  output logic              is_nan_o,
  output logic              is_inf_o,
  output logic signed [9:0] e_o,
  output logic [SIG_W-1:0]  sig_o
);

  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W-1:0] mant_f;

  assign sign_o    = fp_i[31];
  assign exp_f     = fp_i[30:23];
  assign mant_f    = fp_i[22:0];

  assign is_zero_o = (exp_f == '0);
  assign is_nan_o  = (exp_f == '1) && (mant_f != '0);
  assign is_inf_o  = (exp_f == '1) && (mant_f == '0);
  assign e_o       = $signed({2'b00, exp_f}) - 10'(FP32_BIAS);
  assign sig_o     = {1'b1, mant_f};

endmodule

// File: rtl/ieee754_to_u16.sv
// Multi-cycle IEEE 754 single-precision to unsigned integer converter.
// The significand is shifted right one bit per cycle, so latency depends
// on the exponent (s+3 cycles from accept to out_valid on the shift path,
// 2 cycles for operands decided in UNPACK).
// Ports:
//   clk_100k, reset_n     : clock, asynchronous active-low reset
//   in_valid/in_ready     : operand handshake; in_ready only in IDLE
//   in_float              : 32-bit float operand
//   out_valid/out_ready   : result handshake; result held until accepted
//   out_u                 : OUT_W-bit unsigned result
//   out_flags             : {nan, neg, ovf}
//   dbg_state             : current FSM state
// Handshake rule: a transfer happens on a rising edge where valid && ready
// are both high; valid, once raised, stays high with stable data until
// that edge.
// Build option: ROUND_NEAREST_EN selects round-to-nearest-even; without
// it the result is truncated toward zero.
module ieee754_to_u16
  import ieee754_conv_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk_100k,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_float,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_u,
  output logic [2:0]       out_flags,
  output conv_state_e      dbg_state
);

  localparam logic signed [9:0] OUT_W_S = 10'(OUT_W);
  localparam logic signed [9:0] E_MIN   = -10'sd1;

  conv_state_e       state_q, state_d;
  logic [31:0]       op_q, op_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              guard_q, guard_d;
  logic              sticky_q, sticky_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_u_q, out_u_d;
  logic [2:0]        flags_q, flags_d;

  logic              up_sign, up_zero, up_nan, up_inf;
  logic signed [9:0] up_e;
  logic [SIG_W-1:0]  up_sig;
  logic signed [9:0] shift_amt;
  logic              round_inc;
  logic [OUT_W:0]    round_sum;

  fp32_unpack u_unpack (
    .fp_i      (op_q),
    .sign_o    (up_sign),
    .is_zero_o (up_zero),
    .is_nan_o  (up_nan),
    .is_inf_o  (up_inf),
    .e_o       (up_e),
    .sig_o     (up_sig)
  );

  // Only evaluated for e in -1..OUT_W-1, so the amount is 24 down to
  // 24-OUT_W and always fits the 5-bit counter.
  assign shift_amt = 10'sd23 - up_e;

`ifdef ROUND_NEAREST_EN
  // Ties go to the even neighbour: a bare half only rounds up when the
  // retained lsb is odd.
  assign round_inc = guard_q & (sticky_q | sig_q[0]);
`else
  assign round_inc = 1'b0;
`endif

  // After the shift the retained value is below 2^OUT_W, so the upper
  // significand bits are zero and only a rounding carry can overflow.
  assign round_sum = {1'b0, sig_q[OUT_W-1:0]} + (OUT_W+1)'(round_inc);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sig_d       = sig_q;
    cnt_d       = cnt_q;
    guard_d     = guard_q;
    sticky_d    = sticky_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_u_d     = out_u_q;
    flags_d     = flags_q;

    unique case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          op_d       = in_float;
          in_ready_d = 1'b0;
          state_d    = ST_UNPACK;
        end
      end

      ST_UNPACK: begin
        sig_d    = up_sig;
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        out_u_d  = '0;
        flags_d  = '0;
        state_d  = ST_DONE;
        // Class priority: NaN, zero/denormal (so -0.0 is flag-free),
        // negative, overflow, underflow; anything left is shifted.
        if (up_nan) begin
          flags_d[FLAG_NAN] = 1'b1;
        end else if (up_zero) begin
          flags_d = '0;
        end else if (up_sign) begin
          flags_d[FLAG_NEG] = 1'b1;
        end else if (up_inf || (up_e >= OUT_W_S)) begin
          out_u_d           = '1;
          flags_d[FLAG_OVF] = 1'b1;
        end else if (up_e < E_MIN) begin
          flags_d = '0;
        end else begin
          cnt_d   = shift_amt[4:0];
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        sig_d    = sig_q >> 1;
        guard_d  = sig_q[0];
        sticky_d = sticky_q | guard_q;
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = ST_ROUND;
        end
      end

      ST_ROUND: begin
        flags_d = '0;
        if (round_sum[OUT_W]) begin
          out_u_d           = '1;
          flags_d[FLAG_OVF] = 1'b1;
        end else begin
          out_u_d = round_sum[OUT_W-1:0];
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        // First DONE cycle raises out_valid; the result was loaded on
        // entry, so it is already stable when valid appears.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100k or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      sig_q       <= '0;
      cnt_q       <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_u_q     <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sig_q       <= sig_d;
      cnt_q       <= cnt_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_u_q     <= out_u_d;
      flags_q     <= flags_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_u     = out_u_q;
  assign out_flags = flags_q;
  assign dbg_state = state_q;

endmodule
